// File: rtl/ftoi_if.sv
// Handshake bundle shared by the FPU conversion units: operand, start request,
// registered result, one-cycle valid pulse and the ready-for-work flag.
interface ftoi_if;
  logic [31:0] x1;
  logic        en;
  logic [31:0] y;
  logic        valid;
  logic        idle;

  // Dispatcher side: issues operands, observes results.
  modport master (
    output x1,
    output en,
    input  y,
    input  valid,
    input  idle
  );

  // Converter side: consumes operands, produces results.
  modport slave (
    input  x1,
    input  en,
    output y,
    output valid,
    output idle
  );
endinterface

// File: rtl/ftoi.sv
// Multi-cycle binary32 -> signed 32-bit integer converter.
// Three-cycle sequence IDLE -> SHIFT -> OUT; out-of-range and NaN inputs
// saturate by sign. ROUND_MODE 0 rounds to nearest (ties away from zero),
// ROUND_MODE 1 truncates toward zero.
module ftoi #(
  parameter int ROUND_MODE = 0
) (
  input logic   clk,
  input logic   reset,
  ftoi_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]  state_reg;
  logic        sign_reg;
  logic [7:0]  exp_reg;
  logic [23:0] man_reg;
  logic        small_reg;   // |x| < 0.5 (covers zero and subnormals)
  logic        ovf_reg;     // |x| >= 2^31, Inf or NaN
  // The rounded magnitude never exceeds 2^31, so 32 bits hold it exactly.
  logic [31:0] mag_reg;
  logic [31:0] y_reg;
  logic        valid_reg;
  logic        idle_reg;

  logic [7:0]  shift_amt;
  logic [31:0] twice_floor;  // floor(2*|x|) for exponents 126..157
  logic [31:0] mag_next;
  logic [31:0] result_next;

  // Align the mantissa so bit 0 is the half-unit, then round or truncate.
  always_comb begin
    shift_amt   = 8'd181 - exp_reg;
    twice_floor = 32'({man_reg, 32'b0} >> shift_amt);
    mag_next    = '0;
    if (!small_reg) begin
      if (ROUND_MODE == 0) begin
        mag_next = {1'b0, twice_floor[31:1]} + {31'b0, twice_floor[0]};
      end else begin
        mag_next = {1'b0, twice_floor[31:1]};
      end
    end
  end

  // Apply sign, or saturate by sign when the operand is out of range.
  always_comb begin
    result_next = sign_reg ? (32'd0 - mag_reg) : mag_reg;
    if (ovf_reg) begin
      result_next = sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Sequencer: latch operand, compute magnitude, publish result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      man_reg   <= '0;
      small_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      mag_reg   <= '0;
      y_reg     <= '0;
      valid_reg <= 1'b0;
      idle_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          valid_reg <= 1'b0;
          idle_reg  <= 1'b1;
          if (bus.en) begin
            sign_reg  <= bus.x1[31];
            exp_reg   <= bus.x1[30:23];
            man_reg   <= {1'b1, bus.x1[22:0]};
            small_reg <= (bus.x1[30:23] < 8'd126);
            ovf_reg   <= (bus.x1[30:23] >= 8'd158);
            idle_reg  <= 1'b0;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          mag_reg   <= mag_next;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          y_reg     <= result_next;
          valid_reg <= 1'b1;
          idle_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          idle_reg  <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y     = y_reg;
  assign bus.valid = valid_reg;
  assign bus.idle  = idle_reg;

endmodule

// File: tb/tb_ftoi.sv
// Bench for ftoi: one converter per rounding mode, driven by the same stimulus.
// A real-arithmetic reference model plus a timeline of expected handshake
// outputs is checked every cycle; directed vectors carry literal expectations.
module tb_ftoi;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x1;
  logic        en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ftoi_if bus0 ();
  ftoi_if bus1 ();

  assign bus0.x1 = x1;
  assign bus0.en = en;
  assign bus1.x1 = x1;
  assign bus1.en = en;

  ftoi #(.ROUND_MODE(0)) u_rn (.clk(clk), .reset(reset), .bus(bus0));
  ftoi #(.ROUND_MODE(1)) u_rz (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: decode the float to a real value and round it arithmetically.
  function automatic logic [31:0] model(input logic [31:0] x, input int rm);
    int    e;
    real   a;
    real   r;
    logic [31:0] mag;
    e = int'(x[30:23]);
    if (e == 255) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e == 0) a = real'(x[22:0]) * (2.0 ** (-149));
    else        a = real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
    if (a >= 2147483648.0) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r   = (rm == 0) ? $floor(a + 0.5) : $floor(a);
    mag = 32'(longint'(r));
    return x[31] ? (32'd0 - mag) : mag;
  endfunction

  // Expected-output timeline: an accepted request yields a result two edges later.
  int          busy_left = 0;
  logic [31:0] held_x = '0;
  logic        started = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_idle = 1'b1;
  logic [31:0] exp_y0 = '0;
  logic [31:0] exp_y1 = '0;

  // Advance the expected outputs on each active edge.
  always @(posedge clk) begin
    if (reset) begin
      started   <= 1'b1;
      busy_left <= 0;
      exp_valid <= 1'b0;
      exp_idle  <= 1'b1;
      exp_y0    <= '0;
      exp_y1    <= '0;
    end else if (busy_left == 0) begin
      exp_valid <= 1'b0;
      if (en) begin
        held_x    <= x1;
        busy_left <= 2;
        exp_idle  <= 1'b0;
      end else begin
        exp_idle <= 1'b1;
      end
    end else if (busy_left == 2) begin
      busy_left <= 1;
    end else begin
      busy_left <= 0;
      exp_valid <= 1'b1;
      exp_idle  <= 1'b1;
      exp_y0    <= model(held_x, 0);
      exp_y1    <= model(held_x, 1);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("valid_rn", {31'b0, bus0.valid}, {31'b0, exp_valid});
      check("idle_rn",  {31'b0, bus0.idle},  {31'b0, exp_idle});
      check("y_rn",     bus0.y, exp_y0);
      check("valid_rz", {31'b0, bus1.valid}, {31'b0, exp_valid});
      check("idle_rz",  {31'b0, bus1.idle},  {31'b0, exp_idle});
      check("y_rz",     bus1.y, exp_y1);
    end
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y_rn;
    logic [31:0] y_rz;
  } vec_t;

  vec_t vecs[$];

  // Issue one operation, disturb x1 while busy, and check latency and result.
  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    x1 = v.x;
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    x1  = ~v.x;
    lat = 1;
    while (!bus0.valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_%08h", v.x), 32'(lat), 32'd3);
    check($sformatf("rn_%08h", v.x), bus0.y, v.y_rn);
    check($sformatf("rz_%08h", v.x), bus1.y, v.y_rz);
    check($sformatf("model_rn_%08h", v.x), model(v.x, 0), v.y_rn);
    check($sformatf("model_rz_%08h", v.x), model(v.x, 1), v.y_rz);
    $display("op x1=%08h rn=%08h rz=%08h latency=%0d", v.x, bus0.y, bus1.y, lat);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    en    = 1'b0;
    x1    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_y",     bus0.y, 32'h0);
    check("reset_valid", {31'b0, bus0.valid}, 32'h0);
    check("reset_idle",  {31'b0, bus0.idle},  32'h1);
    repeat (3) @(negedge clk);
    check("idle_no_valid", {31'b0, bus0.valid}, 32'h0);

    vecs = '{
      '{32'h3F800000, 32'h00000001, 32'h00000001},
      '{32'hC2F60000, 32'hFFFFFF85, 32'hFFFFFF85},
      '{32'hC0200000, 32'hFFFFFFFD, 32'hFFFFFFFE},
      '{32'h3F000000, 32'h00000001, 32'h00000000},
      '{32'hBF000000, 32'hFFFFFFFF, 32'h00000000},
      '{32'h3ECCCCCD, 32'h00000000, 32'h00000000},
      '{32'h3FFFFFFF, 32'h00000002, 32'h00000001},
      '{32'h3FC00000, 32'h00000002, 32'h00000001},
      '{32'hBFC00000, 32'hFFFFFFFE, 32'hFFFFFFFF},
      '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80},
      '{32'hCEFFFFFF, 32'h80000080, 32'h80000080},
      '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{32'hCF000000, 32'h80000000, 32'h80000000},
      '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{32'hFFC00000, 32'h80000000, 32'h80000000},
      '{32'h80000000, 32'h00000000, 32'h00000000},
      '{32'h00000001, 32'h00000000, 32'h00000000}
    };
    foreach (vecs[i]) run_op(vecs[i]);

    // Continuous en: one result every three cycles.
    @(negedge clk);
    x1     = 32'h40400000;
    en     = 1'b1;
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus0.valid) pulses++;
    end
    en = 1'b0;
    check("back_to_back_pulses", 32'(pulses), 32'd3);
    check("back_to_back_y", bus0.y, 32'h00000003);
    $display("op back-to-back x1=40400000 pulses=%0d", pulses);

    // Reset while in SHIFT aborts the conversion.
    @(negedge clk);
    x1 = 32'h42280000;
    en = 1'b1;
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle",  {31'b0, bus0.idle},  32'h1);
    check("abort_valid", {31'b0, bus0.valid}, 32'h0);
    check("abort_y",     bus0.y, 32'h0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    $display("op abort-in-shift x1=42280000 pulses=%0d", pulses);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
